bcd_to_onehot_stream_decoder: RTL and testbench
===============================================

// Module: bcd_to_onehot_stream_decoder
// PURPOSE
//  Decoder counterpart of the decimal-to-BCD encoder. Accepts a packed multi-digit
//  BCD word over valid/ready, then emits one 10-bit one-hot decimal line per digit,
//  one digit per output handshake. Flags non-BCD nibbles per digit and per word.
//  Sits between BCD arithmetic/counter logic and display or one-hot consumers.
// PARAMETERS
//  NDIG       4   digits per input word; legal range 1..8
//  LSD_FIRST  1   1: emit digit 0 (bits [3:0]) first; 0: emit digit NDIG-1 first
// PORTS
//  clk         in   1        clock; all state changes on rising edge
//  rst_n       in   1        reset, asynchronous, active-low
//  in_valid    in   1        input word valid
//  in_ready    out  1        block can accept a word
//  in_bcd      in   4*NDIG   packed BCD word; digit k = in_bcd[4k+3:4k]
//  out_valid   out  1        out_* fields valid
//  out_ready   in   1        consumer accepts current digit
//  out_onehot  out  10       one-hot decimal: bit d set for digit value d
//  out_idx     out  IW       digit position k, IW = max(1,$clog2(NDIG))
//  out_last    out  1        final digit of the word
//  out_err     out  1        current nibble is 10..15 (not BCD)
//  word_err    out  1        valid only with out_last: any nibble of the word was 10..15
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; out_valid=0, out_onehot=0, out_idx=0,
//    out_last=0, out_err=0, word_err=0, internal word/count cleared; in_ready=1 once
//    rst_n deasserted. Reset mid-word discards the word; no digits emitted after.
//  - FSM: IDLE, EMIT. in_ready = (state==IDLE), combinational from state only.
//  - IDLE: in_valid&&in_ready at edge -> capture in_bcd, load first digit into the
//    registered out_* fields, out_valid=1, go EMIT. Latency: first digit visible
//    cycle after input handshake.
//  - EMIT: out_* fields held stable while out_valid&&!out_ready.
//    out_valid&&out_ready and !out_last -> advance to next digit (k+1 if LSD_FIRST,
//    else k-1), next cycle shows it. With out_last -> out_valid=0, go IDLE.
//  - One-cycle bubble: in_ready rises the cycle after the last digit handshake;
//    in_valid during EMIT is ignored (not captured); source must hold it.
//  - Decode: nibble d in 0..9 -> out_onehot = 10'b1<<d, out_err=0. Nibble 10..15
//    -> out_onehot = 0, out_err=1. Never more than one bit of out_onehot set.
//  - word_err = OR of out_err over all digits of the word, accumulated from the
//    captured word at load time; driven only when out_last, else 0.
//  - out_last = 1 on digit NDIG-1 (LSD_FIRST=1) or digit 0 (LSD_FIRST=0).
//    NDIG=1: first digit is also last; out_idx stays 0.
//  - out_idx: 0..NDIG-1, no wrap beyond word; reset to start index on each capture.
//  - Throughput: NDIG+1 cycles per word with out_ready held 1.
// TESTING
//  1 Assert rst_n=0 mid-cycle -> all outputs 0 immediately; in_ready=1 after release.
//  2 NDIG=4, LSD_FIRST=1, in_bcd=16'h1234, out_ready=1 -> onehot 0x010,0x008,0x004,
//    0x002, idx 0..3, out_last on 4th only, word_err=0; in_ready back 1 cycle later.
//  3 Same word, out_ready low 3 cycles on digit 1 -> out_onehot=0x008, idx=1 held
//    stable; resumes correctly; no digit lost or duplicated.
//  4 in_bcd=16'h9A05 -> onehot 0x020,0x001 err=0; 0x000 err=1; 0x200 err=0,
//    out_last=1, word_err=1.
//  5 LSD_FIRST=0, in_bcd=16'h0709 -> onehot 0x001,0x080,0x001,0x200, idx 3,2,1,0.
//  6 in_valid held with new word during EMIT -> not taken until IDLE; rst_n pulse
//    after digit 1 -> out_valid=0 at once, next word decodes from digit 0.

Source files
------------

// File: rtl/bcd_to_onehot_stream_decoder.sv
// Packed-BCD word to one-hot digit stream: captures NDIG nibbles, emits one 10-bit
// one-hot line per digit, and flags non-BCD nibbles per digit and per word.
module bcd_to_onehot_stream_decoder #(
  parameter int NDIG      = 4,
  parameter bit LSD_FIRST = 1'b1,
  localparam int IW       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [9:0]        out_onehot,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              out_err,
  output logic              word_err,
  output logic              state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // sender holds its payload stable until then, and out_* never change while
  // out_valid && !out_ready.

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [IW-1:0] START_IDX = LSD_FIRST ? '0 : IW'(NDIG - 1);
  localparam logic [IW-1:0] LAST_IDX  = LSD_FIRST ? IW'(NDIG - 1) : '0;

  state_t              state_q, state_d;
  logic [4*NDIG-1:0]   word_q, word_d;
  logic                bad_q, bad_d;
  logic [IW-1:0]       idx_d;
  logic                valid_d, last_d, err_d, werr_d;
  logic [9:0]          onehot_d;
  logic [10:0]         dec;

  // {err, onehot}: non-BCD nibbles produce an all-zero line with err set.
  function automatic logic [10:0] decode(input logic [3:0] n);
    decode = '0;
    if (n <= 4'd9) decode[9:0] = 10'(1) << n;
    else           decode[10]  = 1'b1;
  endfunction

  function automatic logic any_bad(input logic [4*NDIG-1:0] w);
    any_bad = 1'b0;
    for (int k = 0; k < NDIG; k++) any_bad |= (w[4*k +: 4] > 4'd9);
  endfunction

  function automatic logic [3:0] nibble(input logic [4*NDIG-1:0] w, input logic [IW-1:0] k);
    nibble = w[4*int'(k) +: 4];
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign state_dbg = (state_q == EMIT);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bad_d    = bad_q;
    idx_d    = out_idx;
    valid_d  = out_valid;
    onehot_d = out_onehot;
    err_d    = out_err;
    last_d   = out_last;
    werr_d   = word_err;
    dec      = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = EMIT;
          word_d   = in_bcd;
          bad_d    = any_bad(in_bcd);
          idx_d    = START_IDX;
          dec      = decode(nibble(in_bcd, START_IDX));
          valid_d  = 1'b1;
          onehot_d = dec[9:0];
          err_d    = dec[10];
          last_d   = (START_IDX == LAST_IDX);
          werr_d   = (START_IDX == LAST_IDX) && bad_d;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
            err_d    = 1'b0;
            last_d   = 1'b0;
            werr_d   = 1'b0;
            idx_d    = '0;
          end else begin
            idx_d    = LSD_FIRST ? out_idx + IW'(1) : out_idx - IW'(1);
            dec      = decode(nibble(word_q, idx_d));
            onehot_d = dec[9:0];
            err_d    = dec[10];
            last_d   = (idx_d == LAST_IDX);
            werr_d   = (idx_d == LAST_IDX) && bad_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      bad_q      <= 1'b0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
      word_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bad_q      <= bad_d;
      out_idx    <= idx_d;
      out_valid  <= valid_d;
      out_onehot <= onehot_d;
      out_err    <= err_d;
      out_last   <= last_d;
      word_err   <= werr_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_onehot_stream_decoder.sv
// Drives one input stream into an LSD-first and an MSD-first decoder in lockstep
// and checks each emitted digit against a digit-by-digit reference model.
module tb_bcd_to_onehot_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_bcd;
  logic        out_ready;

  logic       a_ready, a_valid, a_last, a_err, a_werr, a_dbg;
  logic [9:0] a_onehot;
  logic [1:0] a_idx;
  logic       b_ready, b_valid, b_last, b_err, b_werr, b_dbg;
  logic [9:0] b_onehot;
  logic [1:0] b_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_to_onehot_stream_decoder #(.NDIG(4), .LSD_FIRST(1'b1)) u_lsd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready), .in_bcd(in_bcd),
    .out_valid(a_valid), .out_ready(out_ready), .out_onehot(a_onehot), .out_idx(a_idx),
    .out_last(a_last), .out_err(a_err), .word_err(a_werr), .state_dbg(a_dbg)
  );

  bcd_to_onehot_stream_decoder #(.NDIG(4), .LSD_FIRST(1'b0)) u_msd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready), .in_bcd(in_bcd),
    .out_valid(b_valid), .out_ready(out_ready), .out_onehot(b_onehot), .out_idx(b_idx),
    .out_last(b_last), .out_err(b_err), .word_err(b_werr), .state_dbg(b_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: position p of the output sequence maps to digit k; each one-hot
  // bit d is set exactly when the nibble equals d.
  task automatic chk_dut(input string nm, input bit msd, input int p, input logic [15:0] w,
                         input logic v, input logic [9:0] oh, input logic [1:0] ix,
                         input logic ls, input logic er, input logic we, input logic rd,
                         input logic dbg);
    int k;
    logic [3:0] nib;
    logic [9:0] exp_oh;
    logic bad;
    k   = msd ? 3 - p : p;
    nib = w[4*k +: 4];
    for (int d = 0; d < 10; d++) exp_oh[d] = (int'(nib) == d);
    bad = 1'b0;
    for (int j = 0; j < 4; j++) if (w[4*j +: 4] > 4'd9) bad = 1'b1;
    chk({nm, " valid"},    v,  1);
    chk({nm, " onehot"},   oh, exp_oh);
    chk({nm, " idx"},      ix, k);
    chk({nm, " last"},     ls, (p == 3));
    chk({nm, " err"},      er, (nib > 4'd9));
    chk({nm, " word_err"}, we, (p == 3) && bad);
    chk({nm, " in_ready"}, rd, 0);
    chk({nm, " busy"},     dbg, 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " a_valid"}, a_valid, 0);
    chk({tag, " b_valid"}, b_valid, 0);
    chk({tag, " a_ready"}, a_ready, 1);
    chk({tag, " b_ready"}, b_ready, 1);
  endtask

  task automatic chk_cleared(input string tag);
    chk_idle(tag);
    chk({tag, " a_onehot"}, a_onehot, 0);
    chk({tag, " b_onehot"}, b_onehot, 0);
    chk({tag, " a_idx"},    a_idx, 0);
    chk({tag, " b_idx"},    b_idx, 0);
    chk({tag, " last"},     {a_last, b_last}, 0);
    chk({tag, " err"},      {a_err, b_err}, 0);
    chk({tag, " word_err"}, {a_werr, b_werr}, 0);
    chk({tag, " busy"},     {a_dbg, b_dbg}, 0);
  endtask

  // Called at a falling edge. Holds out_ready low for stall_len cycles while
  // position stall_pos is shown; hold keeps in_valid up with the next word.
  task automatic send_word(input logic [15:0] w, input int stall_pos, input int stall_len,
                           input bit rnd, input bit hold, input logic [15:0] nxt);
    int n, p, stalled, guard;
    n = 0;
    while (!(a_ready && b_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready wait", a_ready && b_ready, 1);
    in_valid  = 1'b1;
    in_bcd    = w;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (hold) in_bcd = nxt;
    else      in_valid = 1'b0;
    p = 0; stalled = 0; guard = 0;
    while (p < 4 && guard < 60) begin
      chk_dut("lsd", 1'b0, p, w, a_valid, a_onehot, a_idx, a_last, a_err, a_werr, a_ready, a_dbg);
      chk_dut("msd", 1'b1, p, w, b_valid, b_onehot, b_idx, b_last, b_err, b_werr, b_ready, b_dbg);
      if (p == stall_pos && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (out_ready) p++;
      guard++;
    end
    chk("digits emitted", p, 4);
    out_ready = 1'b0;
    chk_idle("after word");
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post reset");

    send_word(16'h1234, -1, 0, 1'b0, 1'b0, '0);
    send_word(16'h1234, 1, 3, 1'b0, 1'b0, '0);
    send_word(16'h9A05, -1, 0, 1'b0, 1'b0, '0);
    send_word(16'h0709, -1, 0, 1'b0, 1'b0, '0);
    send_word(16'h4321, 2, 2, 1'b0, 1'b1, 16'h8765);
    send_word(16'h8765, -1, 0, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of a word, while digit 1 is on display.
    in_valid = 1'b1; in_bcd = 16'h2468;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk_dut("lsd pre-rst", 1'b0, 1, 16'h2468, a_valid, a_onehot, a_idx, a_last, a_err, a_werr, a_ready, a_dbg);
    #2 rst_n = 1'b0;
    #1 chk_cleared("async reset");
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk_cleared("reset discard");
    out_ready = 1'b0;
    send_word(16'h1357, -1, 0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 4; j++)
        w[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      send_word(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1,
                1'($urandom_range(0, 1)), w ^ 16'h1111);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
